// File: rtl/char_uart_tx_pkg.sv
// Shared definitions for the character-stream UART transmitter:
// FSM encodings, ASCII control codes and the CR/LF substitution helper.
package char_uart_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  // An LF leaves the FIFO as a CR; the LF itself follows as a second frame.
  function automatic logic [7:0] crlf_map(input logic [7:0] b, input logic en);
    return (en && (b == ASCII_LF)) ? ASCII_CR : b;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO with asynchronous read data, so a pop and the
// consumer's load of the head byte happen on the same clock edge.
module char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Pointers carry one extra bit so the difference can reach DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/char_uart_tx.sv
// Character stream to 8N1 UART: non-zero bytes are queued in a FIFO and
// shifted out LSB first, with optional LF -> CR LF expansion.
module char_uart_tx
  import char_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int CRLF         = 1,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in,
  input  logic          clr_ovf,
  output logic          txd,
  output logic          busy,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic          lf_reg, lf_next;
  logic          txd_reg, txd_next;
  logic          busy_reg;
  logic          ovf_reg;

  logic       push, pop, drop, full, empty, baud_done;
  logic [7:0] rd_data;

  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign push      = (in != ASCII_NUL) && (!full || pop);
  assign drop      = (in != ASCII_NUL) && full && !pop;
  assign baud_done = (baud_reg == CW'(CLKS_PER_BIT - 1));

  char_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_done ? '0 : baud_reg + 1'b1;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    lf_next    = lf_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = crlf_map(rd_data, CRLF != 0);
          lf_next    = (CRLF != 0) && (rd_data == ASCII_LF);
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          bit_next   = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          if (bit_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_next   = bit_reg + 1'b1;
            shreg_next = {1'b0, shreg_reg[7:1]};
          end
        end
      end
      default: begin
        // End of stop bit: a pending LF takes priority over the FIFO.
        if (baud_done) begin
          if (lf_reg) begin
            shreg_next = ASCII_LF;
            lf_next    = 1'b0;
            state_next = ST_START;
          end else if (!empty) begin
            pop        = 1'b1;
            shreg_next = crlf_map(rd_data, CRLF != 0);
            lf_next    = (CRLF != 0) && (rd_data == ASCII_LF);
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase

    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shreg_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      lf_reg    <= 1'b0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      lf_reg    <= lf_next;
      txd_reg   <= txd_next;
      busy_reg  <= (state_next != ST_IDLE) || (level != '0);
      if (drop)         ovf_reg <= 1'b1;
      else if (clr_ovf) ovf_reg <= 1'b0;
    end
  end

  assign txd      = txd_reg;
  assign busy     = busy_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_char_uart_tx.sv
// Bench for char_uart_tx: directed and random character streams checked against
// a frame-level model of the queue and a mid-bit sampling UART receiver.
module tb_char_uart_tx;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic [7:0] in0 = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       clr0 = 1'b0;
  logic       txd, busy, overflow;
  logic [2:0] level;
  logic       txd0, busy0, overflow0;
  logic [2:0] level0;

  always #5 clk = ~clk;

  char_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .CRLF(1)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_byte), .clr_ovf(clr_ovf),
    .txd(txd), .busy(busy), .level(level), .overflow(overflow)
  );

  char_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .CRLF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .clr_ovf(clr0),
    .txd(txd0), .busy(busy0), .level(level0), .overflow(overflow0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO contents, the cycle the line is free again, overflow flag.
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_cycle = 0;
  int         m_free_at = 0;
  bit         m_ovf = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: detects a start bit, then samples every bit at its middle.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         frame_err = 0;
  bit         rx_en = 1'b0;
  logic [7:0] rx_b;
  int         rx_t0;
  bit         rx_ok;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && rst_n && txd === 1'b0) begin
        rx_t0 = cyc;
        rx_ok = 1'b1;
        repeat (2) @(negedge clk);
        if (txd !== 1'b0) rx_ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          rx_b[k] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) rx_ok = 1'b0;
        if (!rx_ok) frame_err++;
        rx_q.push_back(rx_b);
        rx_t.push_back(rx_t0);
        $display("rx frame %02h start cycle %0d", rx_b, rx_t0);
      end
    end
  end

  // One clock: drive inputs on negedge, advance the model, return 1ns after posedge.
  task automatic tick(input logic [7:0] b, input logic clr, input logic [7:0] b0);
    bit         pop, full, drop;
    logic [7:0] p;
    @(negedge clk);
    in_byte = b;
    clr_ovf = clr;
    in0     = b0;
    if (!rst_n) begin
      m_fifo.delete();
      m_free_at = 0;
      m_ovf     = 1'b0;
    end else begin
      full = (m_fifo.size() >= DEP);
      pop  = (m_fifo.size() > 0) && (m_cycle >= m_free_at);
      drop = (b != 8'h00) && full && !pop;
      if (pop) begin
        p = m_fifo.pop_front();
        if (p == 8'h0A) begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
          m_free_at = m_cycle + 2 * FRAME;
        end else begin
          exp_q.push_back(p);
          m_free_at = m_cycle + FRAME;
        end
      end
      if (b != 8'h00 && !drop) m_fifo.push_back(b);
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    m_cycle++;
    @(posedge clk);
    #1;
  endtask

  int rx_base = 0, exp_base = 0, ferr_base = 0;

  task automatic compare_rx(input string tag);
    int g = 0;
    int n;
    while ((m_fifo.size() != 0 || m_cycle < m_free_at + 4) && g < 3000) begin
      tick(8'h00, 1'b0, 8'h00);
      g++;
    end
    chk({tag, "_drain"}, int'(g < 3000), 1);
    n = exp_q.size() - exp_base;
    chk({tag, "_nframes"}, rx_q.size() - rx_base, n);
    for (int i = 0; i < n && (rx_base + i) < rx_q.size(); i++)
      chk({tag, "_byte"}, int'(rx_q[rx_base + i]), int'(exp_q[exp_base + i]));
    chk({tag, "_framing"}, frame_err - ferr_base, 0);
    rx_base   = rx_q.size();
    exp_base  = exp_q.size();
    ferr_base = frame_err;
  endtask

  int         cnt, lows, first;
  logic [9:0] bits0;
  logic [7:0] rb;

  initial begin
    // Reset state
    repeat (3) tick(8'h00, 1'b0, 8'h00);
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (2) tick(8'h00, 1'b0, 8'h00);

    // Single "x": busy spans exactly one frame
    cnt = 0;
    tick(8'h78, 1'b0, 8'h00);
    if (busy) cnt++;
    for (int i = 0; i < 60; i++) begin
      tick(8'h00, 1'b0, 8'h00);
      if (busy) cnt++;
    end
    chk("x_busy_cycles", cnt, FRAME);
    first = rx_base;
    compare_rx("x");
    if (rx_q.size() > first) chk("x_value", int'(rx_q[first]), 8'h78);

    // "xyz\n" back to back: CR inserted, no idle gap
    first = rx_base;
    tick(8'h78, 1'b0, 8'h00);
    tick(8'h79, 1'b0, 8'h00);
    tick(8'h7A, 1'b0, 8'h00);
    tick(8'h0A, 1'b0, 8'h00);
    compare_rx("xyz_lf");
    if (rx_q.size() == first + 5) begin
      for (int i = 0; i < 4; i++)
        chk("xyz_gap", rx_t[first + i + 1] - rx_t[first + i], FRAME);
      chk("xyz_total", rx_t[first + 4] - rx_t[first] + FRAME, 200);
    end

    // Overflow: 41..46 back to back
    for (int i = 0; i < 6; i++) tick(8'h41 + 8'(i), 1'b0, 8'h00);
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    tick(8'h00, 1'b1, 8'h00);
    chk("ovf_clear", int'(overflow), 0);
    compare_rx("ovf");

    // CRLF=0 instance: LF goes out verbatim as one frame
    tick(8'h00, 1'b0, 8'h0A);
    lows = 0;
    bits0 = '0;
    for (int n = 1; n <= 90; n++) begin
      tick(8'h00, 1'b0, 8'h00);
      if (n < 4 * 10 + 3 && ((n - 3) % 4) == 0 && n >= 3) bits0[(n - 3) / 4] = txd0;
      if (n > FRAME && txd0 == 1'b0) lows++;
    end
    rb = bits0[8:1];
    chk("nocrlf_start", int'(bits0[0]), 0);
    chk("nocrlf_byte", int'(rb), 8'h0A);
    chk("nocrlf_stop", int'(bits0[9]), 1);
    chk("nocrlf_no_second", lows, 0);
    chk("nocrlf_busy", int'(busy0), 0);

    // Random bursts against the model
    for (int burst = 0; burst < 8; burst++) begin
      int len;
      logic [7:0] b;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0) b = 8'h00;
        else if ($urandom_range(0, 4) == 0) b = 8'h0A;
        else b = 8'($urandom_range(1, 255));
        tick(b, 1'b0, 8'h00);
        chk("rnd_level", int'(level), m_fifo.size());
        chk("rnd_ovf", int'(overflow), int'(m_ovf));
      end
      compare_rx("rnd");
      tick(8'h00, 1'b1, 8'h00);
      chk("rnd_ovf_clr", int'(overflow), int'(m_ovf));
      $display("burst %0d len %0d done", burst, len);
    end

    // Reset during a data bit aborts the frame at once
    rx_en = 1'b0;
    tick(8'h78, 1'b0, 8'h00);
    repeat (6) tick(8'h00, 1'b0, 8'h00);
    #2;
    chk("mid_data_bit", int'(txd), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", int'(txd), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_level", int'(level), 0);
    repeat (3) tick(8'h00, 1'b0, 8'h00);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(8'h00, 1'b0, 8'h00);
      if (txd == 1'b0) lows++;
    end
    chk("post_rst_no_frame", lows, 0);
    chk("post_rst_busy", int'(busy), 0);
    exp_base = exp_q.size();
    rx_base  = rx_q.size();
    rx_en = 1'b1;

    // Long idle
    lows = 0;
    cnt  = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(8'h00, 1'b0, 8'h00);
      if (txd == 1'b0) lows++;
      if (busy) cnt++;
    end
    chk("idle_txd", lows, 0);
    chk("idle_busy", cnt, 0);
    chk("idle_level", int'(level), 0);
    chk("idle_frames", rx_q.size() - rx_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
